fetch_sequencer: RTL and testbench

- Instruction-fetch front end that produces the 32-bit instruction stream the decode/control stage consumes.
- Closes the loop on the control outputs: takes the EX-resolved pcSig / PC_enable / PC_rst, selects the next PC, and issues requests to instruction memory.
- Buffers returned words in a 2-entry queue toward decode.
- Handles flush on redirect, discard of stale in-flight responses, and halt on EBREAK.

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/fetch_queue.sv | 75 +++++++
 rtl/fetch_sequencer.sv | 149 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path types: PC-select codes, fetch FSM states and queue entry.
// Optional perf counters in fetch_sequencer are enabled by FETCH_PERF_CNT_EN.
package riscv_pkg;

    localparam logic [1:0] PCSIG_SEQ  = 2'b00;
    localparam logic [1:0] PCSIG_BR   = 2'b01;
    localparam logic [1:0] PCSIG_JALR = 2'b10;
    localparam logic [1:0] PCSIG_RST  = 2'b11;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fq_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {inst, pc} between fetch and decode.
// Flush clears all entries; head is shown combinationally, zero when empty.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int CW     = $clog2(QDEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [31:0]   push_inst,
    input  logic [31:0]   push_pc,
    input  logic          pop,
    output logic [31:0]   head_inst,
    output logic [31:0]   head_pc,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(QDEPTH);

    fq_entry_t     mem_q [QDEPTH];
    fq_entry_t     mem_d [QDEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CW'(QDEPTH));
    assign count     = cnt_q;
    assign head_inst = empty ? 32'd0 : mem_q[rd_q].inst;
    assign head_pc   = empty ? 32'd0 : mem_q[rd_q].pc;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        pop_ok  = pop && !empty;
        push_ok = push && !full;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_q] = '{inst: push_inst, pc: push_pc};
                wr_d        = wr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_d = rd_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: PC select, single-outstanding imem requests,
// epoch-based stale-response drop, halt. FETCH_PERF_CNT_EN adds perf counters.
module fetch_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int          QDEPTH       = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        ex_redirect,
    input  logic [1:0]  ex_pc_sig,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_target,
    input  logic [31:0] ex_jalr_target,
    input  logic        ex_pc_enable,
    input  logic        ex_pc_rst,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);
    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d, req_pc_q, req_pc_d;
    logic          req_q, req_d;
    logic          epoch_q, epoch_d, req_epoch_q, req_epoch_d;
    logic          granted, rsp, in_flight;
    logic          q_push, q_pop, q_empty, q_full;
    logic [CW-1:0] q_count, cnt_nxt;

    always_comb begin
        granted     = req_q && imem_gnt;
        rsp         = (state_q == WAIT) && imem_rvalid;
        in_flight   = ((state_q == WAIT) && !imem_rvalid) || granted;
        q_push      = rsp && !ex_redirect && (req_epoch_q == epoch_q) && !q_full;
        q_pop       = !q_empty && id_ready && !ex_redirect;
        state_d     = state_q;
        pc_d        = pc_q;
        epoch_d     = epoch_q;
        req_pc_d    = req_pc_q;
        req_epoch_d = req_epoch_q;
        if (granted) begin
            req_pc_d    = pc_q;
            req_epoch_d = epoch_q;
            pc_d        = pc_q + 32'd4;
            state_d     = WAIT;
        end
        if (rsp) begin
            state_d = FETCH;
        end
        if (ex_redirect) begin
            // A live request keeps WAIT so its response drains under the old epoch
            epoch_d = in_flight ? ~epoch_q : epoch_q;
            state_d = in_flight ? WAIT : FETCH;
            if (ex_pc_rst) begin
                pc_d = RESET_VECTOR;
            end else if (state_q == HALT || !ex_pc_enable) begin
                pc_d    = pc_q;
                state_d = HALT;
            end else if (ex_pc_sig == PCSIG_JALR) begin
                pc_d = word_align({ex_jalr_target[31:1], 1'b0});
            end else if (ex_pc_sig == PCSIG_BR && ex_branch_taken) begin
                pc_d = word_align(ex_target);
            end else begin
                pc_d = pc_q;
            end
        end
        cnt_nxt = ex_redirect ? '0 : q_count + CW'(q_push) - CW'(q_pop);
        req_d   = (state_d == FETCH) && (cnt_nxt < CW'(QDEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_VECTOR;
            req_q       <= 1'b0;
            epoch_q     <= 1'b0;
            req_pc_q    <= '0;
            req_epoch_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            epoch_q     <= epoch_d;
            req_pc_q    <= req_pc_d;
            req_epoch_q <= req_epoch_d;
        end
    end

    fetch_queue #(.QDEPTH(QDEPTH), .CW(CW)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (ex_redirect),
        .push      (q_push),
        .push_inst (imem_rdata),
        .push_pc   (req_pc_q),
        .pop       (q_pop),
        .head_inst (if_inst),
        .head_pc   (if_pc),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count)
    );

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign if_valid  = !q_empty;
    assign halted    = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;
    logic        stale_drop;

    always_comb begin
        stale_drop     = rsp && !q_push;
        perf_fetched_d = sat_add(perf_fetched_q, 32'(q_push));
        perf_flushed_d = sat_add(perf_flushed_q,
                                 (ex_redirect ? 32'(q_count) : 32'd0) + 32'(stale_drop));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: memory model returns addr ^ 32'h13,
// expected {pc, inst} pairs are queued and compared as decode pops them.
module tb_fetch_sequencer;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid, id_ready;
    logic [31:0] if_inst, if_pc;
    logic        ex_redirect, ex_branch_taken, ex_pc_enable, ex_pc_rst;
    logic [1:0]  ex_pc_sig;
    logic [31:0] ex_target, ex_jalr_target;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    fetch_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_inst         (if_inst),
        .if_pc           (if_pc),
        .id_ready        (id_ready),
        .ex_redirect     (ex_redirect),
        .ex_pc_sig       (ex_pc_sig),
        .ex_branch_taken (ex_branch_taken),
        .ex_target       (ex_target),
        .ex_jalr_target  (ex_jalr_target),
        .ex_pc_enable    (ex_pc_enable),
        .ex_pc_rst       (ex_pc_rst),
        .halted          (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_flushed    (perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    // Memory: grants immediately, answers lat cycles after the grant cycle
    int          lat = 0;
    int          wcnt;
    logic        pend;
    logic [31:0] paddr;

    assign imem_gnt    = imem_req;
    assign imem_rvalid = pend && (wcnt == 0);
    assign imem_rdata  = paddr ^ 32'h13;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend  <= 1'b0;
            wcnt  <= 0;
            paddr <= 32'd0;
        end else begin
            if (imem_rvalid) pend <= 1'b0;
            else if (pend) wcnt <= wcnt - 1;
            if (imem_req && imem_gnt) begin
                pend  <= 1'b1;
                paddr <= imem_addr;
                wcnt  <= lat;
            end
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [1:0]  sig;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] jt;
        logic        prst;
        logic [31:0] exp_pc;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = pc ^ 32'h13;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (!rst && imem_req)
            chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        if (!rst && if_valid && id_ready && !ex_redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h expected none", if_pc);
            end else begin
                e = exp_q.pop_front();
                chk("if_pc", if_pc, e.pc);
                chk("if_inst", if_inst, e.inst);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            cyc();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clr_redirect();
        ex_redirect     = 1'b0;
        ex_pc_sig       = PCSIG_SEQ;
        ex_branch_taken = 1'b0;
        ex_target       = 32'd0;
        ex_jalr_target  = 32'd0;
        ex_pc_enable    = 1'b1;
        ex_pc_rst       = 1'b0;
    endtask

    task automatic reset_dut(input int l, input logic rdy);
        rst      = 1'b1;
        lat      = l;
        id_ready = rdy;
        clr_redirect();
        exp_q.delete();
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    task automatic redir(input logic [1:0] sig, input logic tk,
                         input logic [31:0] tgt, input logic [31:0] jt,
                         input logic prst, input logic pen);
        ex_redirect     = 1'b1;
        ex_pc_sig       = sig;
        ex_branch_taken = tk;
        ex_target       = tgt;
        ex_jalr_target  = jt;
        ex_pc_rst       = prst;
        ex_pc_enable    = pen;
        cyc();
        clr_redirect();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{PCSIG_BR,   1'b1, 32'h0000_0100, 32'h0,   1'b0, 32'h0000_0100};
        vecs[1] = '{PCSIG_JALR, 1'b0, 32'h0,         32'h203, 1'b0, 32'h0000_0200};
        vecs[2] = '{PCSIG_RST,  1'b0, 32'h0,         32'h0,   1'b1, 32'h0000_0000};
        vecs[3] = '{PCSIG_BR,   1'b1, 32'hFFFF_FFFC, 32'h0,   1'b0, 32'hFFFF_FFFC};
        vecs[4] = '{PCSIG_BR,   1'b1, 32'h0000_0500, 32'h0,   1'b1, 32'h0000_0000};
        vecs[5] = '{PCSIG_JALR, 1'b1, 32'h0000_0600, 32'h7FF, 1'b0, 32'h0000_07FC};
        vecs[6] = '{PCSIG_BR,   1'b0, 32'h0000_0900, 32'h0,   1'b0, 32'h0000_0008};
        vecs[7] = '{PCSIG_SEQ,  1'b1, 32'h0000_0900, 32'h0,   1'b0, 32'h0000_0008};

        #2;
        // Reset values and sequential zero-wait stream
        reset_dut(0, 1'b1);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 32'd0);
        chk("rst_perf_flushed", perf_flushed, 32'd0);
`endif
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        drain(30);
        chk("seq_halted", 32'(halted), 32'd0);

        // Decode stall: queue fills, requests stop, nothing lost
        reset_dut(0, 1'b0);
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        push_exp(32'hC);
        repeat (10) cyc();
        chk("stall_imem_req", 32'(imem_req), 32'd0);
        chk("stall_if_valid", 32'(if_valid), 32'd1);
        chk("stall_head_pc", if_pc, 32'h0);
        id_ready = 1'b1;
        drain(40);

        // Redirect during an in-flight request: stale response dropped
        reset_dut(3, 1'b1);
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        n = 0;
        while (!(imem_req && imem_gnt && imem_addr == 32'hC) && n < 100) begin
            cyc();
            n++;
        end
        chk("wait_req12", 32'(n < 100), 32'd1);
        cyc();
        chk("pre_flush_drained", 32'(exp_q.size()), 32'd0);
        chk("req12_in_flight", 32'(pend), 32'd1);
        redir(PCSIG_BR, 1'b1, 32'h100, 32'h0, 1'b0, 1'b1);
        push_exp(32'h100);
        push_exp(32'h104);
        drain(60);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_flushed", perf_flushed, 32'd1);
        chk("perf_fetched", perf_fetched, 32'd5);
`endif

        // Table of redirects from a full, idle queue (pc sits at 8)
        for (int i = 0; i < 8; i++) begin
            reset_dut(0, 1'b0);
            repeat (8) cyc();
            redir(vecs[i].sig, vecs[i].tk, vecs[i].tgt, vecs[i].jt,
                  vecs[i].prst, 1'b1);
            chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'd1);
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_pc);
            id_ready = 1'b1;
            push_exp(vecs[i].exp_pc);
            push_exp(vecs[i].exp_pc + 32'd4);
            drain(30);
        end

        // EBREAK halt, then restart through pc_rst
        reset_dut(0, 1'b0);
        repeat (8) cyc();
        redir(PCSIG_SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        id_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_imem_req", 32'(imem_req), 32'd0);
            cyc();
        end
        redir(PCSIG_SEQ, 1'b1, 32'h300, 32'h0, 1'b0, 1'b1);
        chk("halt_sticky", 32'(halted), 32'd1);
        redir(PCSIG_RST, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        chk("unhalt_halted", 32'(halted), 32'd0);
        chk("unhalt_addr", imem_addr, 32'h0);
        push_exp(32'h0);
        push_exp(32'h4);
        drain(30);

        // Asynchronous reset in the middle of WAIT
        reset_dut(3, 1'b0);
        n = 0;
        while (!(if_valid && pend) && n < 50) begin
            cyc();
            n++;
        end
        chk("wait_mid_wait", 32'(n < 50), 32'd1);
        chk("pre_rst_if_valid", 32'(if_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_imem_req", 32'(imem_req), 32'd0);
        chk("arst_if_valid", 32'(if_valid), 32'd0);
        chk("arst_if_inst", if_inst, 32'd0);
        chk("arst_if_pc", if_pc, 32'd0);
        chk("arst_halted", 32'(halted), 32'd0);
        exp_q.delete();
        repeat (2) cyc();
        rst = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
